uart_rx_sampler: RTL and testbench

//  Serial-to-parallel UART receiver: 8 data bits, LSB first, 1 start, 1 stop, no parity by default.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx_sampler.sv | 114 +++++++++++
 tb/tb_uart_rx_sampler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: RX serial line plus received-byte status, grouped for uart_rx_sampler.
interface uart_rx_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Busy;
  logic       o_Frame_Err;
  logic       o_Parity_Err;
  modport master (input i_Rx_Serial, output o_Rx_DV, o_Rx_Byte, o_Rx_Busy, o_Frame_Err, o_Parity_Err);
  modport slave  (output i_Rx_Serial, input o_Rx_DV, o_Rx_Byte, o_Rx_Busy, o_Frame_Err, o_Parity_Err);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver with centre sampling, glitch rejection and framing errors.
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and stop.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 87
) (
  input logic       i_Clock,
  input logic       i_Reset,
  uart_rx_if.master bus
);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP, BRK} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, byte_q, byte_d;
  logic [1:0]    sync_q;
  logic          dv_q, dv_d, fe_q, fe_d, pe_q, pe_d, busy_q, busy_d, par_q, par_d;
  logic          rx_s, tick;
  assign rx_s = sync_q[1];
  assign tick = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    busy_d  = busy_q;
    par_d   = par_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : START;
        busy_d  = !rx_s;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : DATA;
        busy_d  = !rx_s;
      end
      DATA: if (tick) begin
        shift_d[idx_q] = rx_s;
        idx_d = idx_q + 3'd1;
        state_d = idx_q != 3'd7 ? DATA : PAR_EN ? PARITY : STOP;
      end
      PARITY: if (tick) begin
        par_d   = rx_s;
        state_d = STOP;
      end
      STOP: if (tick) begin
        byte_d  = rx_s ? shift_q : byte_q;
        dv_d    = rx_s;
        pe_d    = rx_s & PAR_EN & (par_q != ^shift_q);
        fe_d    = !rx_s;
        state_d = rx_s ? CLEANUP : BRK;
      end
      CLEANUP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      BRK: begin
        state_d = rx_s ? IDLE : BRK;
        busy_d  = !rx_s;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end
  // Synchronizer resets to 1 so the idle line is not mistaken for a start bit.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      sync_q  <= 2'b11;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      sync_q  <= {sync_q[0], bus.i_Rx_Serial};
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      busy_q  <= busy_d;
      par_q   <= par_d;
    end
  end
  assign bus.o_Rx_DV        = dv_q;
  assign bus.o_Rx_Byte      = byte_q;
  assign bus.o_Rx_Busy      = busy_q;
  assign bus.o_Frame_Err    = fe_q;
  assign bus.o_Parity_Err   = pe_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames against a scoreboard of expected bytes and parity flags.
module tb_uart_rx_sampler;
`ifdef UART_RX_PARITY_EN
  localparam int CPB = 16;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int CPB = 8;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int HALF = (CPB - 1) / 2;
  typedef struct packed {logic [7:0] b; logic pe;} rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int clash_cnt = 0;
  int rd = 0;
  rec_t exp_q[$];
  rec_t rcv_q[$];
  always #5 clk = ~clk;
  uart_rx_if bus();
  uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (.i_Clock(clk), .i_Reset(rst), .bus(bus));
  always @(negedge clk) begin
    if (bus.o_Rx_DV) rcv_q.push_back({bus.o_Rx_Byte, bus.o_Parity_Err});
    if (bus.o_Frame_Err) fe_cnt <= fe_cnt + 1;
    if (bus.o_Rx_DV && bus.o_Frame_Err) clash_cnt <= clash_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic bit_out(input logic v);
    bus.i_Rx_Serial = v;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic flip);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    if (PAR_EN) bit_out(^b ^ flip);
    bit_out(stop);
  endtask
  task automatic expect_byte(input logic [7:0] b, input logic flip);
    exp_q.push_back({b, PAR_EN & flip});
  endtask
  task automatic score(input string tag);
    rec_t e;
    chk({tag, "_count"}, rcv_q.size() - rd, exp_q.size());
    while (exp_q.size() > 0 && rd < rcv_q.size()) begin
      e = exp_q.pop_front();
      chk({tag, "_byte"}, rcv_q[rd].b, e.b);
      chk({tag, "_perr"}, rcv_q[rd].pe, e.pe);
      rd++;
    end
    exp_q.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] b;
    bus.i_Rx_Serial = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dv", bus.o_Rx_DV, 0);
    chk("rst_byte", bus.o_Rx_Byte, 0);
    chk("rst_busy", bus.o_Rx_Busy, 0);
    chk("rst_ferr", bus.o_Frame_Err, 0);
    chk("rst_perr", bus.o_Parity_Err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    expect_byte(8'h37, 1'b0);
    fork
      send(8'h37, 1'b1, 1'b0);
      begin
        repeat (CPB * 3) @(negedge clk);
        chk("t1_busy_mid", bus.o_Rx_Busy, 1);
      end
    join
    repeat (4) @(negedge clk);
    chk("t1_busy_end", bus.o_Rx_Busy, 0);
    score("t1");
    chk("t1_ferr", fe_cnt, 0);
    expect_byte(8'h00, 1'b0);
    expect_byte(8'hFF, 1'b0);
    expect_byte(8'hA5, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    score("t2");
    chk("t2_hold", bus.o_Rx_Byte, 8'hA5);
    bus.i_Rx_Serial = 1'b0;
    repeat (2) @(negedge clk);
    bus.i_Rx_Serial = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_busy_rise", bus.o_Rx_Busy, 1);
    repeat (HALF + 4) @(negedge clk);
    chk("t3_busy_fall", bus.o_Rx_Busy, 0);
    score("t3");
    chk("t3_ferr", fe_cnt, 0);
    send(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("t4_ferr", fe_cnt, 1);
    chk("t4_busy_break", bus.o_Rx_Busy, 1);
    chk("t4_hold", bus.o_Rx_Byte, 8'hA5);
    score("t4_nodv");
    bus.i_Rx_Serial = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_busy_idle", bus.o_Rx_Busy, 0);
    expect_byte(8'h3C, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    score("t4_next");
    b = 8'h81;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(b[i]);
    bus.i_Rx_Serial = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_byte_clr", bus.o_Rx_Byte, 0);
    chk("t5_busy_clr", bus.o_Rx_Busy, 0);
    bus.i_Rx_Serial = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    expect_byte(8'h81, 1'b0);
    send(8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    score("t5");
`ifdef UART_RX_PARITY_EN
    expect_byte(8'h07, 1'b0);
    send(8'h07, 1'b1, 1'b0);
    expect_byte(8'h07, 1'b1);
    send(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    score("t6");
`endif
    chk("no_clash", clash_cnt, 0);
    chk("ferr_total", fe_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
